// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the frog/car game controller: state encoding, field widths
// and small helpers used by the sequencer and its display consumers.
package game_sequencer_pkg;

    localparam int LEVEL_W = 5;
    localparam int LIVES_W = 2;
    localparam int HOLD_W  = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DEATH     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } state_e;

    // Next level, saturating at max_level so the display never wraps.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] level,
                                                     input logic [LEVEL_W-1:0] max_level);
        logic [LEVEL_W-1:0] res;
        if (level >= max_level) begin
            res = max_level;
        end else begin
            res = level + 5'd1;
        end
        return res;
    endfunction

    function automatic logic is_legal_state(input state_e st);
        logic ok;
        case (st)
            IDLE, PLAY, DEATH, LEVEL_UP, GAME_OVER: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/game_sequencer_hold_timer.sv
// Loadable down-counter that times the frozen DEATH / LEVEL_UP holds.
module hold_timer
    import game_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              done
);

    logic [HOLD_W-1:0] count_r;

    // Count register: load wins, otherwise decrement while enabled and non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {HOLD_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {HOLD_W{1'b0}})) begin
            count_r <= count_r - 24'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = en && (count_r == {HOLD_W{1'b0}});

endmodule

// File: rtl/game_sequencer.sv
// Game controller: sequences idle/play/death/level-up/game-over, owns level and lives,
// and produces the registered frog-respawn, level-up and car-enable controls.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter logic [LIVES_W-1:0] START_LIVES = 2'd3,
    parameter logic [LEVEL_W-1:0] MAX_LEVEL   = 5'd31,
    parameter logic [HOLD_W-1:0]  HOLD_CYCLES = 24'd12500000
)(
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic               i_Frog_At_Top,
    input  logic               i_Collision,
    output logic [2:0]         o_State,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Reset_Frog,
    output logic               o_Cars_Run,
    output logic               o_Level_Up,
    output logic               o_Game_Over
);

    state_e               state_r, state_nxt_s;
    logic [LEVEL_W-1:0]   level_r, level_nxt_s;
    logic [LIVES_W-1:0]   lives_r, lives_nxt_s;
    logic                 start_q_r, start_edge_s;
    logic                 reset_frog_r, reset_frog_nxt_s;
    logic                 level_up_r, level_up_nxt_s;
    logic                 cars_run_r, game_over_r;
    logic                 timer_load_s, timer_en_s, timer_done_s;

    assign start_edge_s = i_Start & ~start_q_r;
    assign timer_en_s   = (state_r == DEATH) || (state_r == LEVEL_UP);

    hold_timer u_hold_timer (
        .clk      (i_Clk),
        .rst_n    (i_Rst_L),
        .load     (timer_load_s),
        .load_val (HOLD_CYCLES - 24'd1),
        .en       (timer_en_s),
        .done     (timer_done_s)
    );

    // Next-state logic; start edge outranks collision, which outranks goal.
    always_comb begin
        state_nxt_s      = state_r;
        level_nxt_s      = level_r;
        lives_nxt_s      = lives_r;
        reset_frog_nxt_s = 1'b0;
        level_up_nxt_s   = 1'b0;
        timer_load_s     = 1'b0;
        if (!is_legal_state(state_r)) begin
            state_nxt_s = IDLE;
        end else if (start_edge_s) begin
            state_nxt_s      = PLAY;
            level_nxt_s      = 5'd0;
            lives_nxt_s      = START_LIVES;
            reset_frog_nxt_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                PLAY: begin
                    if (i_Collision) begin
                        if (lives_r > 2'd1) begin
                            lives_nxt_s  = lives_r - 2'd1;
                            timer_load_s = 1'b1;
                            state_nxt_s  = DEATH;
                        end else begin
                            lives_nxt_s = 2'd0;
                            state_nxt_s = GAME_OVER;
                        end
                    end else if (i_Frog_At_Top) begin
                        level_nxt_s    = level_inc(level_r, MAX_LEVEL);
                        level_up_nxt_s = 1'b1;
                        timer_load_s   = 1'b1;
                        state_nxt_s    = LEVEL_UP;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                // Collisions and goals are ignored while frozen.
                DEATH, LEVEL_UP: begin
                    if (timer_done_s) begin
                        state_nxt_s      = PLAY;
                        reset_frog_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                GAME_OVER: begin
                    lives_nxt_s = 2'd0;
                    state_nxt_s = GAME_OVER;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r      <= IDLE;
            level_r      <= 5'd0;
            lives_r      <= START_LIVES;
            start_q_r    <= 1'b0;
            reset_frog_r <= 1'b0;
            level_up_r   <= 1'b0;
            cars_run_r   <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            level_r      <= level_nxt_s;
            lives_r      <= lives_nxt_s;
            start_q_r    <= i_Start;
            reset_frog_r <= reset_frog_nxt_s;
            level_up_r   <= level_up_nxt_s;
            cars_run_r   <= (state_nxt_s == PLAY);
            game_over_r  <= (state_nxt_s == GAME_OVER);
        end
    end

    assign o_State      = state_r;
    assign o_Level      = level_r;
    assign o_Lives      = lives_r;
    assign o_Reset_Frog = reset_frog_r;
    assign o_Cars_Run   = cars_run_r;
    assign o_Level_Up   = level_up_r;
    assign o_Game_Over  = game_over_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with HOLD_CYCLES=4, START_LIVES=3.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       top = 1'b0;
    logic       coll = 1'b0;
    logic [2:0] st;
    logic [4:0] lvl;
    logic [1:0] lives;
    logic       rf, cr, lu, go;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic start, top, coll;
        int   st, lvl, lives, rf, cr, lu, go;
    } vec_t;

    vec_t vq[$];

    game_sequencer #(
        .START_LIVES (2'd3),
        .MAX_LEVEL   (5'd31),
        .HOLD_CYCLES (24'd4)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Start       (start),
        .i_Frog_At_Top (top),
        .i_Collision   (coll),
        .o_State       (st),
        .o_Level       (lvl),
        .o_Lives       (lives),
        .o_Reset_Frog  (rf),
        .o_Cars_Run    (cr),
        .o_Level_Up    (lu),
        .o_Game_Over   (go)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic t, input logic c,
                       input int est, input int elvl, input int eliv,
                       input int erf, input int ecr, input int elu, input int ego);
        vec_t v;
        v.start = s; v.top = t; v.coll = c;
        v.st = est; v.lvl = elvl; v.lives = eliv;
        v.rf = erf; v.cr = ecr; v.lu = elu; v.go = ego;
        vq.push_back(v);
    endtask

    task automatic chk_all(input string p, input vec_t v);
        chk({p, ".state"},      int'(st),    v.st);
        chk({p, ".level"},      int'(lvl),   v.lvl);
        chk({p, ".lives"},      int'(lives), v.lives);
        chk({p, ".reset_frog"}, int'(rf),    v.rf);
        chk({p, ".cars_run"},   int'(cr),    v.cr);
        chk({p, ".level_up"},   int'(lu),    v.lu);
        chk({p, ".game_over"},  int'(go),    v.go);
    endtask

    // One goal pulse followed by a bounded wait for the return to PLAY.
    task automatic goal();
        top = 1'b1;
        @(negedge clk);
        top = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (st == 3'd1) break;
            @(negedge clk);
        end
        chk("goal_return", int'(st), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   n;
        //   start top coll | st lvl liv rf cr lu go
        add(0, 0, 0,  0, 0, 3,  0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 3,  1, 1, 0, 0);
        add(1, 0, 0,  1, 0, 3,  0, 1, 0, 0);
        add(0, 0, 0,  1, 0, 3,  0, 1, 0, 0);
        add(0, 0, 1,  2, 0, 2,  0, 0, 0, 0);
        add(0, 0, 1,  2, 0, 2,  0, 0, 0, 0);
        add(0, 0, 1,  2, 0, 2,  0, 0, 0, 0);
        add(0, 0, 1,  2, 0, 2,  0, 0, 0, 0);
        add(0, 0, 1,  1, 0, 2,  1, 1, 0, 0);
        add(0, 0, 0,  1, 0, 2,  0, 1, 0, 0);
        add(0, 1, 1,  2, 0, 1,  0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 1,  0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 1,  0, 0, 0, 0);
        add(0, 0, 0,  2, 0, 1,  0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 1,  1, 1, 0, 0);
        add(0, 0, 1,  4, 0, 0,  0, 0, 0, 1);
        add(0, 0, 1,  4, 0, 0,  0, 0, 0, 1);
        add(1, 0, 0,  1, 0, 3,  1, 1, 0, 0);
        add(0, 0, 0,  1, 0, 3,  0, 1, 0, 0);
        add(0, 1, 0,  3, 1, 3,  0, 0, 1, 0);
        add(0, 1, 0,  3, 1, 3,  0, 0, 0, 0);
        add(0, 0, 0,  3, 1, 3,  0, 0, 0, 0);
        add(0, 0, 0,  3, 1, 3,  0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 3,  1, 1, 0, 0);
        add(0, 1, 0,  3, 2, 3,  0, 0, 1, 0);
        add(1, 0, 0,  1, 0, 3,  1, 1, 0, 0);
        add(0, 0, 0,  1, 0, 3,  0, 1, 0, 0);

        #1 rst_n = 1'b0;
        #2;
        rv.start = 1'b0; rv.top = 1'b0; rv.coll = 1'b0;
        rv.st = 0; rv.lvl = 0; rv.lives = 3; rv.rf = 0; rv.cr = 0; rv.lu = 0; rv.go = 0;
        chk_all("reset", rv);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start;
            top   = vq[i].top;
            coll  = vq[i].coll;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vq[i]);
        end
        start = 1'b0; top = 1'b0; coll = 1'b0;

        // Drive the level up to the saturation point.
        for (int g = 0; g < 31; g++) goal();
        chk("sat_level_before", int'(lvl), 31);

        top = 1'b1;
        @(negedge clk);
        top = 1'b0;
        chk("sat_level", int'(lvl), 31);
        chk("sat_level_up", int'(lu), 1);
        chk("sat_state", int'(st), 3);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cr == 1'b0) n++;
            else break;
        end
        chk("sat_hold_cycles", n, 4);
        chk("sat_return_state", int'(st), 1);
        chk("sat_return_reset_frog", int'(rf), 1);

        // Reset during the second cycle of a death hold.
        coll = 1'b1;
        @(negedge clk);
        coll = 1'b0;
        chk("mid_death_state", int'(st), 2);
        chk("mid_death_lives", int'(lives), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(st), 0);
        chk("async_rst_cars", int'(cr), 0);
        chk("async_rst_lives", int'(lives), 3);
        chk("async_rst_level", int'(lvl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d.reset_frog", k), int'(rf), 0);
            chk($sformatf("post_rst%0d.state", k), int'(st), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the frog/car game. It sequences the game through idle, play, death-hold, level-up-hold and game-over.
- Owns the level and lives registers, issues the one-cycle frog respawn pulse, and gates car movement through o_Cars_Run.
- Sits between the debounce block, frog_display and the car/VGA/7-segment consumers.
- Replaces the ad-hoc reset_level / level_counter glue.

Parameters:
- START_LIVES, 2'd3: lives loaded at game start; legal range 1..3.
- MAX_LEVEL, 5'd31: level saturation value.
- HOLD_CYCLES, 24'd12500000: i_Clk cycles spent frozen in DEATH and LEVEL_UP (0.5 s at 25 MHz); must be ≥1.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Start  in  1  debounced start/restart request, level-sensitive (all four switches ANDed); rising edge detected internally
- i_Frog_At_Top  in  1  frog reached goal row, 1-cycle pulse
- i_Collision  in  1  frog/car overlap, may be held multiple cycles
- o_State  out  3  current state encoding
- o_Level  out  5  current level, 0-based
- o_Lives  out  2  remaining lives
- o_Reset_Frog  out  1  1-cycle pulse: frog returns to start cell
- o_Cars_Run  out  1  car movement enable
- o_Level_Up  out  1  1-cycle pulse on goal reached
- o_Game_Over  out  1  high while in GAME_OVER

Behaviour:
- Reset (async assert, sync release on i_Clk):
  - state=IDLE, o_Level=0, o_Lives=START_LIVES.
  - All pulse outputs 0, o_Cars_Run=0, o_Game_Over=0, hold timer=0, start-edge register=0.
- All outputs are registered. Response appears on the cycle after the input is sampled.
- start_edge = i_Start & ~start_q. Because start_q resets to 0, i_Start held high at reset release gives exactly one edge.
- Event priority within a cycle: start_edge > i_Collision > i_Frog_At_Top.
- IDLE: o_Cars_Run=0. On start_edge → PLAY with level=0, lives=START_LIVES, o_Reset_Frog pulse.
- PLAY: o_Cars_Run=1.
  - start_edge: restart (level=0, lives=START_LIVES, o_Reset_Frog pulse, stay PLAY).
  - i_Collision with lives>1: lives−1, load timer=HOLD_CYCLES−1, → DEATH.
  - i_Collision with lives==1: lives=0, → GAME_OVER.
  - i_Frog_At_Top: level=min(level+1, MAX_LEVEL), o_Level_Up pulse, load timer, → LEVEL_UP.
- DEATH and LEVEL_UP:
  - o_Cars_Run=0; timer decrements each cycle.
  - i_Collision and i_Frog_At_Top are ignored, so a held collision costs exactly one life.
  - When timer==0: → PLAY with o_Reset_Frog pulse in the same registered cycle.
  - start_edge preempts the hold with a full restart.
- GAME_OVER: o_Game_Over=1, o_Cars_Run=0, lives=0, level held for display. start_edge → full restart into PLAY.
- Hold duration: exactly HOLD_CYCLES cycles with o_Cars_Run=0, counted from the first cycle in the hold state to the last.
- Level at MAX_LEVEL plus goal reached: level stays MAX_LEVEL; o_Level_Up still pulses and LEVEL_UP still runs.
- Reset asserted mid-hold: immediate return to IDLE; timer cleared; no pulse emitted.
- Illegal state encoding: next state = IDLE.

Decomposition:
- Shared header game_defs.vh holds:
  - State localparams: IDLE=3'd0, PLAY=3'd1, DEATH=3'd2, LEVEL_UP=3'd3, GAME_OVER=3'd4.
  - Widths: LEVEL_W=5, LIVES_W=2.
  - vga_display and level display decode o_State and o_Lives from the same header.
- One sub-module, hold_timer: 24-bit loadable down-counter with ports load, load_val, en and done (done when count==0 and en).

Test Plan (HOLD_CYCLES=4, START_LIVES=3):
- Reset released with i_Start=0 → o_State=0, o_Level=0, o_Lives=3, o_Cars_Run=0. Raise i_Start → next cycle o_State=1, one-cycle o_Reset_Frog, o_Cars_Run=1.
- In PLAY, hold i_Collision for 10 cycles → o_Lives=2 only; o_Cars_Run=0 for exactly 4 cycles; then o_State=1 with one o_Reset_Frog pulse.
- Three separate collisions → o_Lives=0, o_State=4, o_Game_Over=1 with no hold. Then an i_Start edge → o_Lives=3, o_Level=0, o_State=1.
- i_Frog_At_Top and i_Collision in the same cycle → collision wins: o_Lives decrements, o_Level unchanged, no o_Level_Up.
- Force o_Level to 31 via 31 goal pulses, then pulse i_Frog_At_Top → o_Level stays 31, o_Level_Up pulses, LEVEL_UP hold of 4 cycles.
- Assert i_Rst_L low during the 2nd cycle of a DEATH hold → asynchronously o_State=0, o_Cars_Run=0, o_Lives=3. No o_Reset_Frog pulse after release.
